alu_issue_stage: RTL

- Sequential front/back stage wrapped around the 12-bit ALU datapath.
- Accepts operations (opcode plus two 12-bit operands) over a valid/ready handshake and registers the operands and the 3-bit select that drive the ALU's 8:1 result mux.
- Captures the mux output one cycle later and presents it with flags on an output valid/ready handshake.
- Decouples the combinational ALU from the producers and consumers of its operations.

---
 rtl/alu_issue_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational 12-bit ALU: registers operands and mux select,
// captures the result one cycle later. Optional macro ALU_FWD_EN forwards the last result as operand A.
module alu_issue_stage #(
  parameter int W    = 12,
  parameter int OPW  = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_fwd_a,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OPW-1:0]  alu_sel,
  input  logic [W-1:0]    alu_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_res,
  output logic [OPW-1:0]  out_op,
  output logic            out_zero,
  output logic            out_neg,
  output logic            busy,
  output logic [CNTW-1:0] txn_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and an offered op must be held until it transfers.
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state, state_nxt;
  logic         accept;
  logic [W-1:0] a_nxt;

`ifdef ALU_FWD_EN
  logic [W-1:0] last_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_res <= '0;
    end else if (state == EXEC) begin
      last_res <= alu_res;
    end
  end

  assign a_nxt = in_fwd_a ? last_res : in_a;
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd_a;
  assign a_nxt      = in_a;
`endif

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_op    <= '0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      txn_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= a_nxt;
        alu_b   <= in_b;
        alu_sel <= in_op;
      end
      // Outputs only change on capture; while DONE without ready they hold.
      if (state == EXEC) begin
        out_valid <= 1'b1;
        out_res   <= alu_res;
        out_op    <= alu_sel;
        out_zero  <= (alu_res == '0);
        out_neg   <= alu_res[W-1];
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

endmodule
